// File: rtl/regfile_mp_if.sv
// regfile_mp_if: groups the write lanes, read ports, PC alias and clear-control signals of regfile_mp.
// Latency: none of its own. It is a bundle of wires.
// Backpressure: none. Writes and reads are fire-and-forget. busy tells the writer that its writes are being dropped.
//
// Signals (master = decode/writeback side, slave = register file):
//   we_a/wa_a/wd_a, we_b/wa_b/wd_b : two write lanes. Lane B carries the younger instruction.
//   ra / rd                        : NRD packed read addresses / read data. Port k is at slice k.
//   r15                            : external PC value, returned for reads of the PC alias index
//   clr_req / busy / clr_done      : clear-sweep request, in-progress flag, completion pulse
//   wr_conflict                    : one-cycle pulse, both lanes wrote the same non-PC register
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int NRD   = 3
);
  localparam int AW = $clog2(NREGS);

  logic                 we_a;
  logic [AW-1:0]        wa_a;
  logic [WIDTH-1:0]     wd_a;
  logic                 we_b;
  logic [AW-1:0]        wa_b;
  logic [WIDTH-1:0]     wd_b;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*WIDTH-1:0] rd;
  logic [WIDTH-1:0]     r15;
  logic                 clr_req;
  logic                 busy;
  logic                 clr_done;
  logic                 wr_conflict;

  modport master (
    output we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra, r15, clr_req,
    input  rd, busy, clr_done, wr_conflict
  );

  modport slave (
    input  we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra, r15, clr_req,
    output rd, busy, clr_done, wr_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NREGS x WIDTH register file with NRD read ports, two write lanes and a sequential clear engine.
// Latency: reads are combinational with zero cycles. Writes are visible the cycle after the edge, or in the same cycle with bypass.
// Backpressure: none. During a clear sweep (busy=1) all writes are dropped, and clr_req is ignored until the FSM is back in IDLE.
//
// Ports:
//   clk   : clock. All state changes on its rising edge.
//   reset : asynchronous, active-low. Clears the array, the FSM and the pulse outputs.
//   bus   : regfile_mp_if.slave. Carries the write lanes A/B, packed read ports ra/rd, the r15 PC alias,
//           clr_req/busy/clr_done and wr_conflict.
//
// Optional build macro REGFILE_BYPASS_EN: when defined, a read that hits an address being written
// this cycle returns the incoming write data. Lane B wins if both lanes hit it.
// When the macro is undefined, reads return the stored value and new data appears one cycle later.
//
// NREGS must be a power of two and at least 4. PC_IDX is an alias and is never stored.
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int NRD    = 3,
  parameter int PC_IDX = 15
) (
  input  logic          clk,
  input  logic          reset,
  regfile_mp_if.slave   bus
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] PC_A   = AW'(PC_IDX);
  localparam logic [AW-1:0] LAST_A = AW'(NREGS - 1);

  // ---------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic          clearing;
  logic          done_pulse;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. clr_req is only looked at in IDLE. Holding it high through DONE
  // therefore restarts the sweep one cycle after the clr_done pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.clr_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (cnt == LAST_A) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode. busy is high exactly for the NREGS clearing cycles.
  always_comb begin
    clearing   = 1'b0;
    done_pulse = 1'b0;
    case (state)
      ST_CLEAR: clearing   = 1'b1;
      ST_DONE:  done_pulse = 1'b1;
      default: begin
        clearing   = 1'b0;
        done_pulse = 1'b0;
      end
    endcase
  end

  assign bus.busy     = clearing;
  assign bus.clr_done = done_pulse;

  // Sweep index. It is loaded with 0 on the edge that enters CLEAR, so every sweep starts at reg 0,
  // even one that follows a reset that interrupted an earlier sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == ST_IDLE && bus.clr_req) begin
      cnt <= '0;
    end else if (clearing) begin
      cnt <= cnt + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Write qualification
  // ---------------------------------------------------------------------------
  // A lane write is effective only outside a sweep and to a real (non-PC) register.
  logic wr_ok_a;
  logic wr_ok_b;
  logic same_addr;

  assign wr_ok_a   = bus.we_a && !clearing && (bus.wa_a != PC_A);
  assign wr_ok_b   = bus.we_b && !clearing && (bus.wa_b != PC_A);
  assign same_addr = wr_ok_a && wr_ok_b && (bus.wa_a == bus.wa_b);

  logic wr_conflict_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_conflict_q <= 1'b0;
    end else begin
      wr_conflict_q <= same_addr;
    end
  end

  assign bus.wr_conflict = wr_conflict_q;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [NREGS];

  // Lane B is assigned after lane A. On a same-address hit the younger instruction's data is
  // therefore the one that lands. mem[PC_IDX] is never written and stays at 0. Reads of that
  // index are served from r15.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (clearing) begin
      mem[cnt] <= '0;
    end else begin
      if (wr_ok_a) mem[bus.wa_a] <= bus.wd_a;
      if (wr_ok_b) mem[bus.wa_b] <= bus.wd_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]     rd_port [NRD];
  logic [NRD*WIDTH-1:0] rd_flat;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;

    assign addr = bus.ra[k*AW +: AW];

    always_comb begin
      rd_port[k] = mem[addr];
`ifdef REGFILE_BYPASS_EN
      // wr_ok_* already excludes sweep cycles and the PC index, so the bypass cannot leak
      // dropped data. Lane B is checked first so that it wins a same-address write.
      if (wr_ok_b && bus.wa_b == addr) begin
        rd_port[k] = bus.wd_b;
      end else if (wr_ok_a && bus.wa_a == addr) begin
        rd_port[k] = bus.wd_a;
      end
`endif
      // The PC alias overrides everything, including reset and sweep states.
      if (addr == PC_A) begin
        rd_port[k] = bus.r15;
      end
    end
  end

  always_comb begin
    rd_flat = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_flat[k*WIDTH +: WIDTH] = rd_port[k];
    end
  end

  assign bus.rd = rd_flat;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus randomized bench for regfile_mp, checked against an array-based reference model.
// Latency: the model is updated once per rising edge, and the DUT outputs are compared on the falling edge.
// Backpressure: not applicable. The bench drives every input directly.
module tb_regfile_mp;

  localparam int W   = 32;
  localparam int N   = 16;
  localparam int NRD = 3;
  localparam int AW  = 4;
  localparam int PC  = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(W), .NREGS(N), .NRD(NRD)) bus ();

  regfile_mp #(.WIDTH(W), .NREGS(N), .NRD(NRD), .PC_IDX(PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register contents plus the sweep position.
  // phase 0 = idle, 1..N = clearing register phase-1, N+1 = done pulse.
  logic [W-1:0] mref [N];
  int           phase;
  logic         exp_busy, exp_done, exp_conf;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mref[i] = '0;
    phase    = 0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_conf = 1'b0;
  endtask

  function automatic logic [W-1:0] rd_of(input int k);
    logic [NRD*W-1:0] flat;
    flat = bus.rd;
    return flat[k*W +: W];
  endfunction

  function automatic logic [W-1:0] exp_rd(input int k);
    logic [NRD*AW-1:0] ra;
    int               addr;
    logic [W-1:0]     v;
    ra   = bus.ra;
    addr = int'(ra[k*AW +: AW]);
    if (addr == PC) return bus.r15;
    v = mref[addr];
`ifdef REGFILE_BYPASS_EN
    if (!(phase >= 1 && phase <= N)) begin
      if (bus.we_b && int'(bus.wa_b) == addr) v = bus.wd_b;
      else if (bus.we_a && int'(bus.wa_a) == addr) v = bus.wd_a;
    end
`endif
    return v;
  endfunction

  // Applies one rising edge to the model, using the inputs as they are at that edge.
  task automatic model_edge();
    bit clr, a_ok, b_ok;
    if (!reset) begin
      model_reset();
    end else begin
      clr  = (phase >= 1 && phase <= N);
      a_ok = bus.we_a && int'(bus.wa_a) != PC && !clr;
      b_ok = bus.we_b && int'(bus.wa_b) != PC && !clr;
      exp_conf = a_ok && b_ok && (bus.wa_a == bus.wa_b);
      if (clr) begin
        mref[phase-1] = '0;
      end else begin
        if (a_ok) mref[bus.wa_a] = bus.wd_a;
        if (b_ok) mref[bus.wa_b] = bus.wd_b;
      end
      if (phase == 0)          phase = bus.clr_req ? 1 : 0;
      else if (phase == N + 1) phase = 0;
      else                     phase = phase + 1;
      exp_busy = (phase >= 1 && phase <= N);
      exp_done = (phase == N + 1);
    end
  endtask

  // One clock: check the combinational reads, take the edge, then check the registered outputs.
  task automatic cycle();
    #1;
    for (int k = 0; k < NRD; k++) check_eq($sformatf("rd%0d", k), rd_of(k), exp_rd(k));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("busy", W'(bus.busy), W'(exp_busy));
    check_eq("clr_done", W'(bus.clr_done), W'(exp_done));
    check_eq("wr_conflict", W'(bus.wr_conflict), W'(exp_conf));
  endtask

  task automatic set_ra(input int p2, input int p1, input int p0);
    bus.ra = {AW'(p2), AW'(p1), AW'(p0)};
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N - 1; i++) begin
      bus.we_a = 1'b1; bus.wa_a = AW'(i); bus.wd_a = W'(i + 1);
      cycle();
    end
    bus.we_a = 1'b0;
  endtask

  // Runs from the cycle after a clr_req edge, counting busy cycles and recording when clr_done fires.
  // The drop_c-th cycle carries a lane-A write to reg 2, which the sweep must discard.
  task automatic run_sweep(input int drop_c, output int busy_cnt, output int done_at);
    busy_cnt = 0;
    done_at  = 0;
    for (int c = 1; c <= N + 4; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.clr_done) done_at = c;
      bus.we_a = (c == drop_c);
      bus.wa_a = AW'(2);
      bus.wd_a = 32'h0000_0BAD;
      cycle();
    end
    bus.we_a = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, da, dones;
    bus.we_a = 0; bus.wa_a = '0; bus.wd_a = '0;
    bus.we_b = 0; bus.wa_b = '0; bus.wd_b = '0;
    bus.ra = '0; bus.r15 = 32'h0000_0108; bus.clr_req = 0;
    model_reset();

    // Reset state
    #2 reset = 1'b0;
    @(negedge clk);
    set_ra(15, 1, 0);
    cycle();
    cycle();
    check_eq("rst_busy", W'(bus.busy), '0);
    check_eq("rst_rd0", rd_of(0), '0);
    check_eq("rst_rd_pc", rd_of(2), 32'h0000_0108);
    reset = 1'b1;
    cycle();

    // Test 1: a single write, read back the next cycle
    bus.we_a = 1; bus.wa_a = 3; bus.wd_a = 32'h0000_00AA;
    set_ra(15, 4, 3);
    cycle();
    bus.we_a = 0;
    #1;
    check_eq("t1_rd0", rd_of(0), 32'h0000_00AA);
    check_eq("t1_rd1", rd_of(1), '0);
    cycle();

    // Test 2: a same-address dual write, then a different-address dual write
    bus.we_a = 1; bus.wa_a = 5; bus.wd_a = 32'h1111_1111;
    bus.we_b = 1; bus.wa_b = 5; bus.wd_b = 32'h2222_2222;
    cycle();
    check_eq("t2_conflict", W'(bus.wr_conflict), 32'd1);
    bus.wa_a = 6; bus.wd_a = 32'h6666_6666;
    bus.wa_b = 7; bus.wd_b = 32'h7777_7777;
    cycle();
    check_eq("t2_noconflict", W'(bus.wr_conflict), '0);
    bus.we_a = 0; bus.we_b = 0;
    set_ra(7, 6, 5);
    #1;
    check_eq("t2_reg5", rd_of(0), 32'h2222_2222);
    check_eq("t2_reg6", rd_of(1), 32'h6666_6666);
    check_eq("t2_reg7", rd_of(2), 32'h7777_7777);
    cycle();

    // Test 3: PC alias. Writes to index 15 are dropped and never flag a conflict.
    bus.r15 = 32'h0000_0108;
    set_ra(15, 5, 3);
    bus.we_a = 1; bus.wa_a = 15; bus.wd_a = 32'h0000_DEAD;
    bus.we_b = 1; bus.wa_b = 15; bus.wd_b = 32'h0000_BEEF;
    cycle();
    check_eq("t3_noconflict", W'(bus.wr_conflict), '0);
    bus.we_a = 0; bus.we_b = 0;
    #1;
    check_eq("t3_pc", rd_of(2), 32'h0000_0108);
    cycle();

    // Test 4: a full clear sweep, with a write in the middle that is dropped
    load_ramp();
    bus.clr_req = 1;
    cycle();
    bus.clr_req = 0;
    set_ra(2, 1, 0);
    run_sweep(5, bc, da);
    check_eq("t4_busy_cycles", W'(bc), W'(N));
    check_eq("t4_done_cycle", W'(da), W'(N + 1));
    for (int j = 0; j < N - 1; j += 3) begin
      set_ra(j + 2, j + 1, j);
      #1;
      for (int k = 0; k < NRD; k++) check_eq($sformatf("t4_cleared%0d", j + k), rd_of(k), '0);
    end
    cycle();

    // Test 5: reset in the middle of a sweep, then a fresh sweep
    load_ramp();
    bus.clr_req = 1;
    cycle();
    bus.clr_req = 0;
    for (int c = 0; c < 7; c++) cycle();
    set_ra(10, 9, 8);
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("t5_busy_now", W'(bus.busy), '0);
    for (int k = 0; k < NRD; k++) check_eq($sformatf("t5_reg%0d", 8 + k), rd_of(k), '0);
    cycle();
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (bus.clr_done) dones++;
    end
    check_eq("t5_no_done", W'(dones), '0);
    bus.we_a = 1; bus.wa_a = 0; bus.wd_a = 32'h0000_005A;
    cycle();
    bus.we_a = 0;
    bus.clr_req = 1;
    set_ra(15, 1, 0);
    cycle();
    bus.clr_req = 0;
    run_sweep(0, bc, da);
    check_eq("t5_busy_cycles", W'(bc), W'(N));
    check_eq("t5_done_cycle", W'(da), W'(N + 1));

    // Test 6: write-read in the same cycle, with and without bypass
    bus.we_a = 1; bus.wa_a = 9; bus.wd_a = 32'h0000_1234;
    cycle();
    bus.wd_a = 32'h0000_0055;
    set_ra(15, 1, 9);
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("t6_same_cycle", rd_of(0), 32'h0000_0055);
`else
    check_eq("t6_same_cycle", rd_of(0), 32'h0000_1234);
`endif
    cycle();
    bus.we_a = 0;
    #1;
    check_eq("t6_next_cycle", rd_of(0), 32'h0000_0055);
    cycle();

    // Randomized traffic, including collisions, PC writes and occasional sweeps
    for (int n = 0; n < 800; n++) begin
      bus.we_a = ($urandom_range(0, 3) != 0);
      bus.we_b = ($urandom_range(0, 2) == 0);
      bus.wa_a = AW'($urandom_range(0, N - 1));
      bus.wa_b = ($urandom_range(0, 3) == 0) ? bus.wa_a : AW'($urandom_range(0, N - 1));
      bus.wd_a = $urandom;
      bus.wd_b = $urandom;
      bus.r15  = $urandom;
      bus.ra   = NRD*AW'($urandom);
      bus.clr_req = ($urandom_range(0, 49) == 0);
      cycle();
    end
    bus.we_a = 0; bus.we_b = 0; bus.clr_req = 0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
